// File: rtl/uart_out_arbiter.sv
// Packet-level round-robin arbiter sharing one UART TX byte stream between requesters.
// A grant covers a whole packet (ended by in_last) or ends after an idle timeout.
module uart_out_arbiter #(
    parameter int Requesters    = 4,
    parameter int DataWidth     = 8,
    parameter int TimeoutCycles = 1024
) (
    input  logic                              clock,
    input  logic                              reset,
    input  logic [Requesters*DataWidth-1:0]   in_data,
    input  logic [Requesters-1:0]             in_valid,
    input  logic [Requesters-1:0]             in_last,
    output logic [Requesters-1:0]             in_ready,
    output logic [DataWidth-1:0]              out_data,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic                              grant_valid,
    output logic [$clog2(Requesters)-1:0]     grant_index,
    output logic                              timeout_pulse
);

    localparam int IW = $clog2(Requesters);
    localparam int CW = $clog2(TimeoutCycles) + 1;
    localparam logic [CW-1:0] CNT_LIMIT = CW'(TimeoutCycles - 1);
    localparam logic [CW-1:0] CNT_MAX   = '1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(Requesters - 1);
    localparam logic [IW:0]   REQ_W     = (IW + 1)'(Requesters);

    // Handshake: a byte moves when out_valid && out_ready; only the holder sees in_ready.
    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [IW-1:0]   grant_nxt;
    logic [IW-1:0]   ptr_q, ptr_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic            pulse_nxt;

    logic [2*Requesters-1:0] dbl;
    logic [Requesters-1:0]   rot;
    logic                    pick_found;
    logic [IW:0]             pick_sum;
    logic [IW-1:0]           pick_idx;

    logic                    hold_valid;
    logic                    hold_last;
    logic [DataWidth-1:0]    hold_data;
    logic [IW-1:0]           rel_ptr;

    // Rotate requests so bit 0 is the pointer position, then take the lowest set bit.
    always_comb begin
        dbl        = {in_valid, in_valid} >> ptr_q;
        rot        = dbl[Requesters-1:0];
        pick_found = 1'b0;
        pick_sum   = '0;
        for (int k = Requesters - 1; k >= 0; k--) begin
            if (rot[k]) begin
                pick_found = 1'b1;
                pick_sum   = {1'b0, ptr_q} + (IW + 1)'(k);
            end
        end
        if (pick_sum >= REQ_W) begin
            pick_sum = pick_sum - REQ_W;
        end
        pick_idx = pick_sum[IW-1:0];
    end

    always_comb begin
        hold_valid = 1'b0;
        hold_last  = 1'b0;
        hold_data  = '0;
        for (int i = 0; i < Requesters; i++) begin
            if (grant_index == IW'(i)) begin
                hold_valid = in_valid[i];
                hold_last  = in_last[i];
                hold_data  = in_data[i*DataWidth +: DataWidth];
            end
        end
        rel_ptr = (grant_index == LAST_IDX) ? '0 : grant_index + IW'(1);
    end

    always_comb begin
        state_nxt = state;
        grant_nxt = grant_index;
        ptr_nxt   = ptr_q;
        cnt_nxt   = cnt_q;
        pulse_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = LOCKED;
                    grant_nxt = pick_idx;
                    cnt_nxt   = '0;
                end
            end
            LOCKED: begin
                if (hold_valid) begin
                    cnt_nxt = '0;
                    if (out_ready && hold_last) begin
                        state_nxt = IDLE;
                        grant_nxt = '0;
                        ptr_nxt   = rel_ptr;
                    end
                end else if (TimeoutCycles != 0 && cnt_q == CNT_LIMIT) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                    ptr_nxt   = rel_ptr;
                    cnt_nxt   = '0;
                    pulse_nxt = 1'b1;
                end else if (TimeoutCycles != 0 && cnt_q != CNT_MAX) begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state         <= IDLE;
            grant_index   <= '0;
            ptr_q         <= '0;
            cnt_q         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            state         <= state_nxt;
            grant_index   <= grant_nxt;
            ptr_q         <= ptr_nxt;
            cnt_q         <= cnt_nxt;
            timeout_pulse <= pulse_nxt;
        end
    end

    // Data path is a pure mux from the holder; nothing is buffered.
    always_comb begin
        grant_valid = (state == LOCKED);
        in_ready    = '0;
        out_valid   = 1'b0;
        out_data    = '0;
        if (state == LOCKED) begin
            out_valid             = hold_valid;
            out_data              = hold_data;
            in_ready[grant_index] = out_ready;
        end
    end

endmodule

// File: tb/tb_uart_out_arbiter.sv
// Directed bench for uart_out_arbiter: per-cycle comparison against a packet-level model,
// plus a wire-order scoreboard and hand-computed expectations for each scenario.
module tb_uart_out_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 8;
    localparam int TMO  = 16;
    localparam int IW   = 2;

    logic                 clock = 1'b0;
    logic                 reset = 1'b0;
    logic [NREQ*DW-1:0]   in_data = '0;
    logic [NREQ-1:0]      in_valid = '0;
    logic [NREQ-1:0]      in_last = '0;
    logic [NREQ-1:0]      in_ready;
    logic [DW-1:0]        out_data;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic                 grant_valid;
    logic [IW-1:0]        grant_index;
    logic                 timeout_pulse;

    uart_out_arbiter #(
        .Requesters   (NREQ),
        .DataWidth    (DW),
        .TimeoutCycles(TMO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .grant_valid  (grant_valid),
        .grant_index  (grant_index),
        .timeout_pulse(timeout_pulse)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fails  = 0;
    int pulse_cnt = 0;

    logic [IW+DW-1:0] exp_q[$];
    logic [DW:0]      tx_q[NREQ][$];
    logic [NREQ-1:0]  fired = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // Model: who holds the wire (-1 = nobody), where the next search starts, idle run length.
    int  m_hold = -1, m_ptr = 0, m_idle = 0;
    bit  m_pulse = 0;
    int  n_hold = -1, n_ptr = 0, n_idle = 0;
    bit  n_pulse = 0;
    bit  model_live = 0;

    always @(negedge clock) begin
        logic [NREQ-1:0] er;
        logic [DW-1:0]   ed;
        if (model_live) begin
            er = '0;
            ed = '0;
            if (m_hold >= 0) begin
                er[m_hold] = out_ready;
                ed = in_data[m_hold*DW +: DW];
            end
            check("grant_valid", grant_valid, m_hold >= 0);
            check("grant_index", grant_index, (m_hold >= 0) ? m_hold : 0);
            check("out_valid", out_valid, (m_hold >= 0) ? in_valid[m_hold] : 1'b0);
            check("out_data", out_data, ed);
            check("in_ready", in_ready, er);
            check("timeout_pulse", timeout_pulse, m_pulse);
            if (reset && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_byte", {grant_index, out_data}, 32'hffff_ffff);
                end else begin
                    check("wire_byte", {grant_index, out_data}, exp_q.pop_front());
                end
            end
            if (timeout_pulse) pulse_cnt++;
        end
        fired = reset ? (in_valid & in_ready) : '0;

        n_hold = m_hold; n_ptr = m_ptr; n_idle = m_idle; n_pulse = 0;
        if (!reset) begin
            n_hold = -1; n_ptr = 0; n_idle = 0;
        end else if (m_hold < 0) begin
            for (int k = 0; k < NREQ; k++) begin
                if (n_hold < 0 && in_valid[(m_ptr + k) % NREQ]) n_hold = (m_ptr + k) % NREQ;
            end
            n_idle = 0;
        end else if (in_valid[m_hold]) begin
            n_idle = 0;
            if (out_ready && in_last[m_hold]) begin
                n_hold = -1;
                n_ptr  = (m_hold + 1) % NREQ;
            end
        end else if (m_idle + 1 >= TMO) begin
            n_hold = -1; n_ptr = (m_hold + 1) % NREQ; n_idle = 0; n_pulse = 1;
        end else begin
            n_idle = m_idle + 1;
        end
    end

    always @(posedge clock) begin
        if (!reset) model_live = 1;
        m_hold = n_hold; m_ptr = n_ptr; m_idle = n_idle; m_pulse = n_pulse;
    end

    // Per-channel feeders: present the head item, advance after it is accepted.
    always @(posedge clock) begin
        #1;
        for (int c = 0; c < NREQ; c++) begin
            if (fired[c] && tx_q[c].size() > 0) void'(tx_q[c].pop_front());
            if (tx_q[c].size() > 0) begin
                in_valid[c]            = 1'b1;
                in_last[c]             = tx_q[c][0][DW];
                in_data[c*DW +: DW]    = tx_q[c][0][DW-1:0];
            end else begin
                in_valid[c]            = 1'b0;
                in_last[c]             = 1'b0;
                in_data[c*DW +: DW]    = '0;
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic neg();
        @(negedge clock);
        #1;
    endtask

    task automatic feed(input int ch, input logic [DW-1:0] d, input bit last);
        tx_q[ch].push_back({last, d});
    endtask

    task automatic push(input int ch, input logic [DW-1:0] d, input bit last);
        feed(ch, d, last);
        exp_q.push_back({IW'(ch), d});
    endtask

    task automatic wait_grant(input int ch, input int budget);
        int n = 0;
        do begin
            neg();
            n++;
        end while (!(grant_valid && grant_index == IW'(ch)) && n < budget);
        check("wait_grant", {31'd0, grant_valid && grant_index == IW'(ch)}, 1);
    endtask

    task automatic wait_drain(input int budget);
        int  n = 0;
        bit  busy;
        do begin
            neg();
            n++;
            busy = (exp_q.size() != 0) || grant_valid;
            for (int c = 0; c < NREQ; c++) if (tx_q[c].size() != 0) busy = 1;
        end while (busy && n < budget);
        check("drain", {31'd0, busy}, 0);
    endtask

    initial begin
        int idle;
        int stable;

        // Reset state
        repeat (3) step();
        reset = 1'b1;
        neg();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_grant_index", grant_index, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_pulse", timeout_pulse, 0);

        // Single requester ch2, 3-byte packet
        step();
        out_ready = 1'b1;
        push(2, 8'h41, 0); push(2, 8'h42, 0); push(2, 8'h43, 1);
        neg();
        neg();
        check("t1_request_cycle_idle", grant_valid, 0);
        neg();
        check("t1_granted", grant_valid, 1);
        check("t1_grant_index", grant_index, 2);
        check("t1_first_byte", out_data, 8'h41);
        wait_drain(20);
        check("t1_released", grant_valid, 0);
        check("t1_model_ptr", m_ptr, 3);

        // ch0 and ch3 together from reset, twice
        step(); reset = 1'b0;
        step(); reset = 1'b1;
        push(0, 8'hA0, 0); push(0, 8'hA1, 1);
        push(3, 8'hB0, 0); push(3, 8'hB1, 1);
        wait_drain(30);
        step();
        push(0, 8'hC0, 1); push(3, 8'hD0, 1);
        wait_drain(30);
        check("t2_model_ptr", m_ptr, 0);

        // ch0 arrives while ch1 holds mid-packet
        step();
        push(1, 8'h11, 0); push(1, 8'h12, 0); push(1, 8'h13, 1);
        wait_grant(1, 10);
        step();
        push(0, 8'h01, 0); push(0, 8'h02, 1);
        neg();
        neg();
        check("t3_ch0_waiting", in_valid[0], 1);
        check("t3_only_ch1_ready", in_ready, 4'b0010);
        wait_drain(30);

        // ch1 stalls after one byte; ch2 pending
        step();
        push(1, 8'h55, 0); push(2, 8'h66, 1);
        wait_grant(1, 10);
        idle = 0;
        for (int i = 0; i < 40; i++) begin
            neg();
            if (timeout_pulse) break;
            if (grant_valid && grant_index == 1 && !in_valid[1]) idle++;
        end
        check("t4_pulse", timeout_pulse, 1);
        check("t4_idle_cycles", idle, 16);
        check("t4_released", grant_valid, 0);
        neg();
        check("t4_next_grant_valid", grant_valid, 1);
        check("t4_next_grant_index", grant_index, 2);
        wait_drain(20);
        check("t4_pulse_count", pulse_cnt, 1);

        // Backpressure 100 cycles is not a stall
        step();
        out_ready = 1'b0;
        push(0, 8'h77, 1);
        wait_grant(0, 10);
        stable = 0;
        repeat (100) begin
            neg();
            if (grant_valid && grant_index == 0 && out_valid && out_data == 8'h77 && !timeout_pulse)
                stable++;
        end
        check("t5_stable_cycles", stable, 100);
        check("t5_no_timeout", pulse_cnt, 1);
        step();
        out_ready = 1'b1;
        wait_drain(20);

        // Reset in the middle of a ch2 packet
        step();
        push(2, 8'h21, 0); feed(2, 8'h22, 0); feed(2, 8'h23, 1);
        wait_grant(2, 10);
        step();
        reset = 1'b0;
        out_ready = 1'b0;
        tx_q[2].delete();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        neg();
        check("t6_grant_valid", grant_valid, 0);
        check("t6_grant_index", grant_index, 0);
        check("t6_in_ready", in_ready, 0);
        check("t6_model_ptr", m_ptr, 0);
        step();
        push(3, 8'h31, 1);
        wait_drain(20);
        check("end_exp_q_empty", exp_q.size(), 0);
        check("end_pulse_count", pulse_cnt, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
